seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one

---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_encode.sv | 17 +
 rtl/seg7_scan_driver.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   SEG_DARK        all segments off (active-high)
//   GLYPH_*         active-high {a,b,c,d,e,f,g} patterns, bit 6 = a
//   blink_phase_e   visible / hidden half of the blink period
//   seg7_glyph()    4-bit code -> active-high pattern; 10-15 are hex glyphs
//                   or dark, depending on hex_en
package seg7_pkg;

    localparam logic [6:0] SEG_DARK = 7'b0000000;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1110011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_e;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_en);
        logic [6:0] pat;
        pat = SEG_DARK;
        case (code)
            4'h0: pat = GLYPH_0;
            4'h1: pat = GLYPH_1;
            4'h2: pat = GLYPH_2;
            4'h3: pat = GLYPH_3;
            4'h4: pat = GLYPH_4;
            4'h5: pat = GLYPH_5;
            4'h6: pat = GLYPH_6;
            4'h7: pat = GLYPH_7;
            4'h8: pat = GLYPH_8;
            4'h9: pat = GLYPH_9;
            4'hA: pat = hex_en ? GLYPH_A : SEG_DARK;
            4'hB: pat = hex_en ? GLYPH_B : SEG_DARK;
            4'hC: pat = hex_en ? GLYPH_C : SEG_DARK;
            4'hD: pat = hex_en ? GLYPH_D : SEG_DARK;
            4'hE: pat = hex_en ? GLYPH_E : SEG_DARK;
            4'hF: pat = hex_en ? GLYPH_F : SEG_DARK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph encoder for the currently scanned digit.
//   code     4-bit BCD/hex code
//   hex_en   1: codes 10-15 render as A,b,C,d,E,F; 0: they render dark
//   dark     force the pattern dark (blank, blink off-phase, suppressed zero)
//   pattern  active-high {a,b,c,d,e,f,g}
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    input  logic       dark,
    output logic [6:0] pattern
);

    assign pattern = dark ? SEG_DARK : seg7_glyph(code, hex_en);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment digits on one segment bus.
//   clk, reset   clock, synchronous active-high reset
//   digits_in    4-bit code per digit, [4i+3:4i] = digit i (digit 0 rightmost)
//   dp_in        decimal point per digit
//   blank_in     force digit dark
//   blink_in     digit dark during the blink off-phase
//   lz_en        leading-zero suppression
//   load         1-cycle strobe: capture all *_in and lz_en
//   load_ack     1-cycle pulse when the loaded data first appears (digit 0)
//   seg_out      {a..g}, bit 6 = a; dp_out decimal point; an_out digit enables
// Loaded data waits in a pending buffer and is promoted only at frame end,
// so a frame never shows a mix of old and new values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_EN       = 0,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_en,
    input  logic                    load,
    output logic                    load_ack,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // XOR masks that map active-high internal values onto pin polarity.
    localparam logic [6:0]            SEG_INV = {7{SEG_ACT_LOW != 0}};
    localparam logic                  DP_INV  = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACT_LOW != 0}};
    localparam logic                  HEX_ON  = (HEX_EN != 0);

    typedef struct packed {
        logic                    lz_en;
        logic [NUM_DIGITS-1:0]   blink;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
        logic [4*NUM_DIGITS-1:0] digits;
    } disp_buf_t;

    logic [TW-1:0] tick;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    blink_phase_e  phase;
    disp_buf_t     active_buf, pending_buf, in_buf;
    logic          pending_valid;
    logic          committed;   // active_buf was replaced at the last frame end
    logic          digit_end, frame_end;

    assign in_buf    = {lz_en, blink_in, blank_in, dp_in, digits_in};
    assign digit_end = (tick == TICK_LAST);
    assign frame_end = digit_end && (idx == IDX_LAST);

    // Scan position: tick within the digit slot, idx = digit being fetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
        end else if (digit_end) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            tick <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Blink phase flips every BLINK_FRAMES frames, aligned to frame ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            phase     <= PHASE_ON;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Pending/active buffers. A load on the frame-end cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: these buffers are plain flops whose contents are visible
            // right after reset (digits show '0'), so they are reset, unlike
            // a RAM-style storage array would be.
            active_buf    <= '0;
            pending_buf   <= '0;
            pending_valid <= 1'b0;
            committed     <= 1'b0;
        end else begin
            committed <= 1'b0;
            if (frame_end) begin
                if (load) begin
                    active_buf <= in_buf;
                    committed  <= 1'b1;
                end else if (pending_valid) begin
                    active_buf <= pending_buf;
                    committed  <= 1'b1;
                end
                pending_valid <= 1'b0;
            end else if (load) begin
                pending_buf   <= in_buf;
                pending_valid <= 1'b1;
            end
        end
    end

    // Per-digit darkness, including leading-zero suppression rippling down
    // from the most significant digit. A nonzero code or a decimal point
    // breaks the run for that digit and all lower ones; digit 0 always shows.
    logic [3:0]            codes [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_sup, digit_dark;
    logic                  lz_run;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign codes[i]      = active_buf.digits[4*i +: 4];
        assign digit_dark[i] = active_buf.blank[i]
                             | (active_buf.blink[i] & (phase == PHASE_OFF))
                             | lz_sup[i];
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        lz_sup = '0;
        lz_run = active_buf.lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run    = lz_run & (codes[i] == 4'd0) & ~active_buf.dp[i];
            lz_sup[i] = lz_run;
        end
    end

    logic [3:0]            cur_code;
    logic                  cur_dark, cur_dp;
    logic [6:0]            cur_pat;
    logic [NUM_DIGITS-1:0] an_onehot;

    assign cur_code = codes[idx];
    assign cur_dark = digit_dark[idx];
    assign cur_dp   = active_buf.dp[idx] & ~cur_dark;

    seg7_encode u_encode (
        .code    (cur_code),
        .hex_en  (HEX_ON),
        .dark    (cur_dark),
        .pattern (cur_pat)
    );

    always_comb begin
        an_onehot      = '0;
        an_onehot[idx] = 1'b1;
    end

    // Output registers: anode, segments, dp and ack all move on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_out   <= AN_INV;
            seg_out  <= SEG_DARK ^ SEG_INV;
            dp_out   <= DP_INV;
            load_ack <= 1'b0;
        end else begin
            an_out   <= an_onehot ^ AN_INV;
            seg_out  <= cur_pat ^ SEG_INV;
            dp_out   <= cur_dp ^ DP_INV;
            load_ack <= committed;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, REFRESH_DIV=4,
// BLINK_FRAMES=2, active-low). Two instances differ only in HEX_EN. The
// reference model derives digit position, frame number and blink phase from
// the cycle count since reset release and keeps the display buffers as
// whole-frame records.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0, blank_in = '0, blink_in = '0;
    logic        lz_en = 1'b0, load = 1'b0;

    logic       load_ack, dp_out, load_ack_h, dp_out_h;
    logic [6:0] seg_out, seg_out_h;
    logic [3:0] an_out, an_out_h;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF),
                       .HEX_EN(0), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en), .load(load),
        .load_ack(load_ack), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out));

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF),
                       .HEX_EN(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut_hex (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en), .load(load),
        .load_ack(load_ack_h), .seg_out(seg_out_h), .dp_out(dp_out_h), .an_out(an_out_h));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp, blank, blink;
        logic        lz;
    } frame_t;

    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    frame_t m_active, m_pending;
    bit     m_pend_valid = 1'b0;
    bit     m_ack_next = 1'b0;
    int     m_edges = 0;      // edges since reset release
    int     ack_seen = 0;

    function automatic frame_t sample_inputs();
        frame_t f;
        f.digits = digits_in;
        f.dp     = dp_in;
        f.blank  = blank_in;
        f.blink  = blink_in;
        f.lz     = lz_en;
        return f;
    endfunction

    function automatic frame_t empty_frame();
        frame_t f;
        f.digits = '0;
        f.dp     = '0;
        f.blank  = '0;
        f.blink  = '0;
        f.lz     = 1'b0;
        return f;
    endfunction

    // Expected {load_ack, dp_out, seg_out, an_out} after the edge closing slot s.
    function automatic logic [12:0] expect_out(input int s, input bit hex);
        int         d   = (s / DIV) % N;
        int         fr  = s / FRAME;
        bit         off = ((fr / BF) % 2) == 1;
        bit         sup = 1'b0;
        bit         dark;
        logic [3:0] code = m_active.digits[4*d +: 4];
        logic [6:0] pat;
        logic [3:0] an;
        if (m_active.lz && d > 0) begin
            sup = 1'b1;
            for (int j = d; j < N; j++)
                if (m_active.digits[4*j +: 4] != 4'd0 || m_active.dp[j]) sup = 1'b0;
        end
        dark = m_active.blank[d] | (m_active.blink[d] & off) | sup;
        pat  = (code > 4'd9 && !hex) ? 7'b0 : glyph_tab[code];
        if (dark) pat = 7'b0;
        an   = 4'b1111;
        an[d] = 1'b0;
        return {m_ack_next, ~(m_active.dp[d] & ~dark), ~pat, an};
    endfunction

    // One clock: check both instances against the model, then advance the
    // model with the inputs that were sampled on that edge.
    task automatic step();
        int s;
        @(posedge clk);
        #1;
        if (reset) begin
            check("reset_out", {load_ack, dp_out, seg_out, an_out}, {1'b0, 1'b1, 7'h7F, 4'hF});
            check("reset_out_hex", {load_ack_h, dp_out_h, seg_out_h, an_out_h},
                  {1'b0, 1'b1, 7'h7F, 4'hF});
            m_active     = empty_frame();
            m_pending    = empty_frame();
            m_pend_valid = 1'b0;
            m_ack_next   = 1'b0;
            m_edges      = 0;
        end else begin
            s = m_edges;
            m_edges++;
            check($sformatf("out@%0d", s), {load_ack, dp_out, seg_out, an_out}, expect_out(s, 1'b0));
            check($sformatf("out_hex@%0d", s), {load_ack_h, dp_out_h, seg_out_h, an_out_h},
                  expect_out(s, 1'b1));
            if (load_ack) ack_seen++;
            m_ack_next = 1'b0;
            if (s % FRAME == FRAME - 1) begin
                if (load) begin
                    m_active   = sample_inputs();
                    m_ack_next = 1'b1;
                end else if (m_pend_valid) begin
                    m_active   = m_pending;
                    m_ack_next = 1'b1;
                end
                m_pend_valid = 1'b0;
            end else if (load) begin
                m_pending    = sample_inputs();
                m_pend_valid = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge samples frame slot t (at most one frame).
    task automatic wait_slot(input int t);
        for (int i = 0; i < FRAME && (m_edges % FRAME) != t; i++) step();
    endtask

    task automatic pulse_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        // Reset held three cycles.
        run(3);
        reset = 1'b0;

        // Every code in digit 0; spot-check a few against literal pin values.
        for (int c = 0; c < 16; c++) begin
            digits_in = 16'(c);
            wait_slot(5);
            pulse_load();
            wait_slot(2);   // digit 0 of the new frame just displayed
            if (c == 9)  check("code9_seg", seg_out, 7'b0001100);
            if (c == 10) check("codeA_dark", seg_out, 7'b1111111);
            if (c == 10) check("codeA_hex", seg_out_h, 7'b0001000);
            if (c == 15) check("codeF_hex", seg_out_h, 7'b0111000);
        end

        // Free run across several frames.
        run(3 * FRAME);

        // Load at tick 2 of digit 1, then two loads within one frame.
        digits_in = 16'h1234;
        wait_slot(DIV + 2);
        ack_seen = 0;
        pulse_load();
        digits_in = 16'hFFFF;
        run(2 * FRAME);
        check("ack_once_1234", 32'(ack_seen), 32'd1);
        digits_in = 16'hAAAA;
        wait_slot(3);
        ack_seen = 0;
        pulse_load();
        digits_in = 16'h5678;
        wait_slot(9);
        pulse_load();
        run(2 * FRAME);
        check("ack_once_double", 32'(ack_seen), 32'd1);

        // Load coincident with frame end.
        digits_in = 16'h9081;
        wait_slot(FRAME - 1);
        pulse_load();
        run(FRAME + 2);

        // Leading-zero suppression, then a decimal point ending it at digit 2.
        digits_in = 16'h0050;
        lz_en = 1'b1;
        wait_slot(4);
        pulse_load();
        run(FRAME + 2);
        dp_in = 4'b0100;
        pulse_load();
        run(FRAME + 2);
        dp_in = '0;
        lz_en = 1'b0;

        // Blink on digit 0 over several blink periods.
        digits_in = 16'h4321;
        blink_in = 4'b0001;
        pulse_load();
        run(5 * FRAME);
        blink_in = '0;

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            for (int d = 0; d < N; d++)
                digits_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            dp_in    = 4'($urandom & $urandom);
            blank_in = 4'($urandom & $urandom & $urandom);
            blink_in = 4'($urandom & $urandom);
            lz_en    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) wait_slot(FRAME - 1);
            else run($urandom_range(0, 20));
            if ($urandom_range(0, 4) != 0) pulse_load();
        end
        dp_in = '0;
        blank_in = '0;
        blink_in = '0;
        lz_en = 1'b0;

        // Reset mid-frame with a load pending: no ack afterwards.
        digits_in = 16'h7777;
        wait_slot(5);
        pulse_load();
        run(3);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        ack_seen = 0;
        run(2 * FRAME);
        check("ack_after_reset", 32'(ack_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
